// File: rtl/hls_motion_accum_obf.sv
// Batch accumulator for the motion MACC stage outputs.
// Sums ACC_DEPTH valid result triples into three wrapping signed sums.
// The batch result is offered downstream with a valid/ready handshake.
// The accept, terminal-count and ready decisions are each XORed with one
// working-key bit.
module hls_motion_accum_obf #(
    parameter int unsigned ACC_DEPTH = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_idle,
    output logic             ap_done,
    input  logic [31:0]      in1,
    input  logic             in1_ap_vld,
    input  logic [31:0]      in2,
    input  logic             in2_ap_vld,
    input  logic [31:0]      in3,
    input  logic             in3_ap_vld,
    output logic [31:0]      sum1,
    output logic [31:0]      sum2,
    output logic [31:0]      sum3,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             proto_err,
    input  logic [3070:0]    locking_key
);

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(ACC_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]       working_key;
    logic             unused_key;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             all_vld;
    logic             any_vld;
    logic             accept;
    logic             terminal;
    logic             handshake;
    logic             restart;
    logic             drop;

    assign working_key = locking_key[2:0];
    assign unused_key  = ^locking_key[3070:3];

    // Decode valids and evaluate the key-locked accept, terminal and ready tests.
    always_comb begin
        all_vld   = in1_ap_vld & in2_ap_vld & in3_ap_vld;
        any_vld   = in1_ap_vld | in2_ap_vld | in3_ap_vld;
        count_inc = count + CNT_W'(1);
        // Each test is stored in inverted or true form so only the correct key bit restores it.
        accept    = (state == S_ACC)  & (~all_vld ^ working_key[0]);
        terminal  = (count_inc == DEPTH) ^ working_key[1];
        handshake = (state == S_DONE) & (~result_ready ^ working_key[2]);
        restart   = ap_start & ((state == S_IDLE) | handshake);
        drop      = all_vld & (state != S_ACC);
    end

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and handshake status outputs.
    always_comb begin
        state_next = state;
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                if (accept && terminal) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (handshake) begin
                    ap_done    = 1'b1;
                    state_next = ap_start ? S_ACC : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Accumulate sums, track the batch count, result flag and error counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sum1         <= '0;
            sum2         <= '0;
            sum3         <= '0;
            count        <= '0;
            result_valid <= 1'b0;
            drop_cnt     <= '0;
            proto_err    <= 1'b0;
        end else begin
            if (restart) begin
                sum1  <= '0;
                sum2  <= '0;
                sum3  <= '0;
                count <= '0;
            end else if (accept) begin
                sum1  <= sum1 + in1;
                sum2  <= sum2 + in2;
                sum3  <= sum3 + in3;
                count <= count_inc;
            end
            if (accept && terminal) begin
                result_valid <= 1'b1;
            end else if (handshake) begin
                result_valid <= 1'b0;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (any_vld && !all_vld) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hls_motion_accum_obf.sv
// Scoreboard bench for hls_motion_accum_obf: stimulus pushes expected batch
// sums, a negedge monitor compares them while result_valid is high.
module tb_hls_motion_accum_obf;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_idle, ap_done;
    logic [31:0]   in1, in2, in3;
    logic          in1_ap_vld, in2_ap_vld, in3_ap_vld;
    logic [31:0]   sum1, sum2, sum3;
    logic          result_valid, result_ready;
    logic [7:0]    drop_cnt;
    logic          proto_err;
    logic [3070:0] locking_key;

    logic          d1_idle, d1_done, d1_valid, d1_perr;
    logic [31:0]   d1_sum1, d1_sum2, d1_sum3;
    logic [7:0]    d1_drop;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] s3;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 1'b0;

    always #5 ap_clk = ~ap_clk;

    hls_motion_accum_obf #(.ACC_DEPTH(8), .CNT_W(8)) u_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_done(ap_done),
        .in1(in1), .in1_ap_vld(in1_ap_vld),
        .in2(in2), .in2_ap_vld(in2_ap_vld),
        .in3(in3), .in3_ap_vld(in3_ap_vld),
        .sum1(sum1), .sum2(sum2), .sum3(sum3),
        .result_valid(result_valid), .result_ready(result_ready),
        .drop_cnt(drop_cnt), .proto_err(proto_err),
        .locking_key(locking_key)
    );

    hls_motion_accum_obf #(.ACC_DEPTH(1), .CNT_W(8)) u_dut1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_idle(d1_idle), .ap_done(d1_done),
        .in1(in1), .in1_ap_vld(in1_ap_vld),
        .in2(in2), .in2_ap_vld(in2_ap_vld),
        .in3(in3), .in3_ap_vld(in3_ap_vld),
        .sum1(d1_sum1), .sum2(d1_sum2), .sum3(d1_sum3),
        .result_valid(d1_valid), .result_ready(result_ready),
        .drop_cnt(d1_drop), .proto_err(d1_perr),
        .locking_key(locking_key)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic triple(input logic v1, input logic v2, input logic v3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        in1_ap_vld = v1; in2_ap_vld = v2; in3_ap_vld = v3;
        in1 = a; in2 = b; in3 = c;
    endtask

    task automatic no_valid();
        triple(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    // Monitor: compare the queue head while a result is presented, pop on handshake.
    always @(negedge ap_clk) begin
        if (mon_en && ap_rst_n) begin
            chk("ap_done", 32'(ap_done), 32'(result_valid && result_ready));
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got result_valid=1, expected no result pending");
                end else begin
                    chk("sum1", sum1, exp_q[0].s1);
                    chk("sum2", sum2, exp_q[0].s2);
                    chk("sum3", sum3, exp_q[0].s3);
                    if (result_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst_n     = 1'b0;
        ap_start     = 1'b0;
        result_ready = 1'b1;
        no_valid();
        locking_key      = '1;
        locking_key[2:0] = 3'b101;
        repeat (2) tick();
        chk("rst_idle",  32'(ap_idle), 32'd1);
        chk("rst_done",  32'(ap_done), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_sum1",  sum1, 32'd0);
        chk("rst_drop",  32'(drop_cnt), 32'd0);
        chk("rst_perr",  32'(proto_err), 32'd0);
        ap_rst_n = 1'b1;
        mon_en   = 1'b1;
        tick();

        // Golden batch: (i, -i, 2i) for i = 1..8.
        exp_q.push_back('{32'd36, 32'hFFFF_FFDC, 32'd72});
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            triple(1'b1, 1'b1, 1'b1, 32'(i), 32'(-i), 32'(2 * i));
            tick();
            if (i == 1) begin
                chk("d1_valid", 32'(d1_valid), 32'd1);
                chk("d1_sum1", d1_sum1, 32'd1);
                chk("d1_sum2", d1_sum2, 32'hFFFF_FFFF);
                chk("d1_sum3", d1_sum3, 32'd2);
            end
        end
        no_valid();
        chk("gold_latency", 32'(result_valid), 32'd1);
        tick();
        chk("gold_idle", 32'(ap_idle), 32'd1);
        chk("gold_valid_clr", 32'(result_valid), 32'd0);

        // Drops in IDLE and in the IDLE->ACC cycle, then a wrapping batch with a stalled consumer.
        triple(1'b1, 1'b1, 1'b1, 32'd9, 32'd9, 32'd9);
        tick();
        tick();
        ap_start = 1'b1;
        tick();
        ap_start     = 1'b0;
        result_ready = 1'b0;
        exp_q.push_back('{32'hFFFF_FFF8, 32'd36, 32'hFFFF_FFF8});
        for (int i = 1; i <= 8; i++) begin
            triple(1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'(i), 32'hFFFF_FFFF);
            tick();
        end
        chk("wrap_latency", 32'(result_valid), 32'd1);
        triple(1'b1, 1'b1, 1'b1, 32'd100, 32'd100, 32'd100);
        tick();
        tick();
        no_valid();
        tick();
        tick();
        chk("stall_valid", 32'(result_valid), 32'd1);
        result_ready = 1'b1;
        ap_start     = 1'b1;
        tick();
        ap_start = 1'b0;
        chk("b2b_not_idle", 32'(ap_idle), 32'd0);
        chk("b2b_valid_clr", 32'(result_valid), 32'd0);
        chk("b2b_sum1_clr", sum1, 32'd0);
        chk("b2b_sum2_clr", sum2, 32'd0);
        chk("b2b_sum3_clr", sum3, 32'd0);
        exp_q.push_back('{32'd36, 32'd72, 32'hFFFF_FF94});
        for (int i = 1; i <= 8; i++) begin
            triple(1'b1, 1'b1, 1'b1, 32'(i), 32'(2 * i), 32'(-3 * i));
            tick();
        end
        no_valid();
        chk("b2b_latency", 32'(result_valid), 32'd1);
        tick();
        chk("drop_count", 32'(drop_cnt), 32'd5);
        chk("b2b_idle", 32'(ap_idle), 32'd1);

        // Partial-valid cycle mid-batch: neither accepted nor dropped.
        exp_q.push_back('{32'd8, 32'd8, 32'd8});
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            triple(1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 32'd1);
            tick();
        end
        triple(1'b1, 1'b0, 1'b0, 32'd1000, 32'd1000, 32'd1000);
        tick();
        chk("perr_set", 32'(proto_err), 32'd1);
        chk("perr_sum1", sum1, 32'd3);
        for (int i = 0; i < 5; i++) begin
            triple(1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 32'd1);
            tick();
        end
        no_valid();
        chk("perr_latency", 32'(result_valid), 32'd1);
        tick();
        triple(1'b0, 1'b1, 1'b0, 32'd7, 32'd7, 32'd7);
        tick();
        no_valid();
        chk("perr_sticky", 32'(proto_err), 32'd1);
        chk("perr_no_drop", 32'(drop_cnt), 32'd5);

        // Drop counter saturation.
        triple(1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 32'd1);
        repeat (249) tick();
        chk("drop_254", 32'(drop_cnt), 32'd254);
        repeat (51) tick();
        no_valid();
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Asynchronous reset in the middle of a batch.
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            triple(1'b1, 1'b1, 1'b1, 32'd5, 32'd6, 32'd7);
            tick();
        end
        no_valid();
        chk("pre_rst_sum1", sum1, 32'd15);
        ap_rst_n = 1'b0;
        #1;
        chk("arst_idle", 32'(ap_idle), 32'd1);
        chk("arst_done", 32'(ap_done), 32'd0);
        chk("arst_valid", 32'(result_valid), 32'd0);
        chk("arst_sum1", sum1, 32'd0);
        chk("arst_sum2", sum2, 32'd0);
        chk("arst_sum3", sum3, 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_perr", 32'(proto_err), 32'd0);
        tick();
        ap_rst_n = 1'b1;
        repeat (3) tick();

        // Wrong key on the golden scenario must not reproduce the golden result.
        mon_en           = 1'b0;
        locking_key[2:0] = 3'b000;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            triple(1'b1, 1'b1, 1'b1, 32'(i), 32'(-i), 32'(2 * i));
            tick();
        end
        no_valid();
        vectors++;
        if (result_valid === 1'b1 && sum1 === 32'd36 && sum2 === 32'hFFFF_FFDC && sum3 === 32'd72) begin
            miscompares++;
            $display("FAIL wrong_key: got golden result valid=%0b sum1=0x%08h, expected a differing result", result_valid, sum1);
        end
        ap_rst_n = 1'b0;
        tick();
        locking_key[2:0] = 3'b101;
        ap_rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hls_motion_accum_obf.md
Name: hls_motion_accum_obf

Overview:
- Downstream consumer of the motion MACC stage (out1/out2/out3 with per-output ap_vld).
- Captures each valid result triple and accumulates ACC_DEPTH triples into three wrapping signed sums.
- Presents the batch result to the next stage with a valid/ready handshake.
- Control branches are key-locked: each is XORed with a working-key bit, consistent with the rest of the obfuscated motion datapath.

Parameters:
ACC_DEPTH, 8, number of triples per batch (1..255)
CNT_W, 8, width of sample counter and drop counter

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  start a batch
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse on result handshake
in1  in  32  signed, from upstream out1
in1_ap_vld  in  1  in1 valid
in2  in  32  signed, from upstream out2
in2_ap_vld  in  1  in2 valid
in3  in  32  signed, from upstream out3
in3_ap_vld  in  1  in3 valid
sum1  out  32  batch sum of in1
sum2  out  32  batch sum of in2
sum3  out  32  batch sum of in3
result_valid  out  1  sums valid
result_ready  in  1  downstream accepts
drop_cnt  out  CNT_W  saturating count of dropped triples
proto_err  out  1  sticky, partial-valid cycle seen
locking_key  in  3071  key bus; working_key = locking_key[2:0]

Behaviour:

Reset:
- ap_rst_n=0 asynchronously forces state IDLE and clears sum1..3, count, drop_cnt, proto_err and result_valid.
- Outputs during and after reset: ap_idle=1, ap_done=0.
- Reset asserted mid-batch or mid-handshake discards everything; no partial result is emitted.

Key:
- Correct key is working_key=3'b101.
- Bit0 inverts the accept test, bit1 inverts the terminal-count test, bit2 inverts the ready test.
- Each inverted test is written so that the correct key restores the function below.
- With any other key, outputs are unspecified; they must differ from golden for at least one test.

Derived signals:
- all_vld = in1_ap_vld & in2_ap_vld & in3_ap_vld.
- any_vld = OR of the three valids.

State ACC:
- all_vld accepts the triple. On the next edge, sumN <= sumN + inN, two's-complement wrap with no saturation, and count <= count+1.
- The edge that takes count to ACC_DEPTH moves the state to DONE and sets result_valid.
- Latency: the final triple, accepted in cycle t, is included in the sums with result_valid=1 at t+1.

State DONE:
- result_valid=1 and sum1..3 held stable.
- result_ready=1 completes the handshake: ap_done=1 combinationally in that cycle, and result_valid=0 from the next cycle.
- Next state is ACC if ap_start=1 in the handshake cycle (sums and count cleared, back-to-back batch); otherwise IDLE.

State IDLE:
- ap_start=1 moves to ACC, clearing sums and count. The first accept is possible in the cycle after.

Boundaries:
- all_vld in IDLE, in DONE, or in the IDLE->ACC transition cycle: the triple is dropped and drop_cnt increments, saturating at all-ones.
- any_vld & !all_vld in any state sets proto_err (sticky until reset); that triple is neither accepted nor dropped.
- ap_start is ignored in ACC and in DONE outside the handshake cycle.
- ACC_DEPTH=1: a single accept goes straight to DONE.
- Sums are registered outputs; their value outside DONE is the live partial sum and is valid only when result_valid=1.

Test Plan:
1. Reset and idle: ap_rst_n low mid-sim -> ap_idle=1, result_valid=0, sums=0, drop_cnt=0, proto_err=0 immediately, without waiting for a clock edge.
2. Golden batch, ACC_DEPTH=8, key=101: ap_start, then 8 triples (i, -i, 2i) for i=1..8 with result_ready=1 -> result_valid=1 one cycle after the 8th accept, sum1=36, sum2=-36 (0xFFFFFFDC), sum3=72, ap_done pulses once, then state IDLE.
3. Wrap and stall: two triples in1=0x7FFFFFFF, ACC_DEPTH=2, result_ready held 0 for 5 cycles -> sum1=0xFFFFFFFE held stable for 5 cycles, ap_done only on the cycle ready rises.
4. Drops and back-to-back: triples arriving in IDLE and in DONE -> drop_cnt counts them; ap_start=1 in the handshake cycle -> ACC entered directly, next batch sums start from 0.
5. Partial valid: in1_ap_vld=1 with in2/in3 valid low -> proto_err=1 sticky, sums and count unchanged.
6. Wrong key 3'b000 on scenario 2 -> result differs from golden (sums, result_valid timing, or ap_idle mismatch).
